// File: rtl/pzcorebus_pkg.sv
// Shared pzcorebus types: bus configuration, response packing widths and the
// response FIFO release-state encoding.
package pzcorebus_pkg;

    typedef enum logic [1:0] {
        PZCOREBUS_MEMORY_H,
        PZCOREBUS_MEMORY_L,
        PZCOREBUS_CSR
    } pzcorebus_profile;

    typedef struct packed {
        pzcorebus_profile profile;
        int               data_width;
        int               id_width;
    } pzcorebus_config;

    localparam int PZCOREBUS_RESPONSE_TYPE_WIDTH = 2;
    localparam int PZCOREBUS_DEFAULT_DATA_WIDTH  = 32;
    localparam int PZCOREBUS_DEFAULT_ID_WIDTH    = 4;

    typedef enum logic [0:0] {
        GATE,
        RELEASE
    } pzcorebus_response_fifo_state;

    // A zero width field selects the default, so an all-zero config is usable.
    function automatic int get_data_width(pzcorebus_config bus_config);
        return (bus_config.data_width > 0) ? bus_config.data_width : PZCOREBUS_DEFAULT_DATA_WIDTH;
    endfunction

    function automatic int get_id_width(pzcorebus_config bus_config);
        return (bus_config.id_width > 0) ? bus_config.id_width : PZCOREBUS_DEFAULT_ID_WIDTH;
    endfunction

    function automatic int get_packed_response_width(pzcorebus_config bus_config);
        return PZCOREBUS_RESPONSE_TYPE_WIDTH + get_id_width(bus_config) + get_data_width(bus_config);
    endfunction

endpackage

// File: rtl/pzcorebus_if.sv
// Response channel of the pzcorebus with packing helpers; the last flag is
// carried separately from the packed response.
interface pzcorebus_if
    import pzcorebus_pkg::*;
#(
    parameter pzcorebus_config BUS_CONFIG = '0
);
    localparam int DATA_WIDTH   = get_data_width(BUS_CONFIG);
    localparam int ID_WIDTH     = get_id_width(BUS_CONFIG);
    localparam int PACKED_WIDTH = get_packed_response_width(BUS_CONFIG);

    logic                                     sresp_valid;
    logic                                     mresp_accept;
    logic [PZCOREBUS_RESPONSE_TYPE_WIDTH-1:0] sresp;
    logic [ID_WIDTH-1:0]                      sid;
    logic [DATA_WIDTH-1:0]                    sdata;
    logic                                     sresp_last;

    function automatic logic [PACKED_WIDTH-1:0] get_packed_response();
        return {sresp, sid, sdata};
    endfunction

    function automatic void put_packed_response(input logic [PACKED_WIDTH-1:0] response);
        {sresp, sid, sdata} = response;
    endfunction

    modport response_slave (
        output sresp_valid, sresp, sid, sdata, sresp_last,
        input  mresp_accept,
        import get_packed_response, put_packed_response
    );

    modport response_master (
        input  sresp_valid, sresp, sid, sdata, sresp_last,
        output mresp_accept,
        import get_packed_response, put_packed_response
    );

endinterface

// File: rtl/pzcorebus_response_fifo_ram.sv
// Circular entry store for the response FIFO; occupancy is tracked by a
// counter so DEPTH need not be a power of two.
module pzcorebus_response_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
)(
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_push,
    input  logic [WIDTH-1:0]               i_data,
    input  logic                           i_pop,
    output logic [WIDTH-1:0]               o_data,
    output logic [$clog2(DEPTH+1)-1:0]     o_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (i_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (i_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (i_push && !i_pop) begin
                o_count <= o_count + 1'b1;
            end else if (i_pop && !i_push) begin
                o_count <= o_count - 1'b1;
            end
        end
    end

    // Entry contents carry no reset; only pointers and occupancy are control.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            storage[wr_ptr] <= i_data;
        end
    end

    assign o_data = storage[rd_ptr];

endmodule

// File: rtl/pzcorebus_response_fifo.sv
// Response-path buffer: stores beats from the downstream slave and replays
// them in order upstream, optionally holding a burst until its last beat lands.
module pzcorebus_response_fifo
    import pzcorebus_pkg::*;
#(
    parameter pzcorebus_config BUS_CONFIG  = '0,
    parameter int              DEPTH       = 4,
    parameter bit              PACKET_MODE = 0
)(
    input  logic                         i_clk,
    input  logic                         i_rst,
    pzcorebus_if.response_slave          slave_if,
    pzcorebus_if.response_master         master_if,
    output logic                         o_empty,
    output logic                         o_full,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int RESPONSE_W = get_packed_response_width(BUS_CONFIG);
    localparam int ENTRY_W    = RESPONSE_W + 1;
    localparam int COUNT_W    = $clog2(DEPTH + 1);

    logic               push;
    logic               pop;
    logic               push_last;
    logic               head_last;
    logic               resp_valid;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;

    assign push      = master_if.sresp_valid && master_if.mresp_accept;
    assign pop       = slave_if.sresp_valid && slave_if.mresp_accept;
    assign push_last = (BUS_CONFIG.profile == PZCOREBUS_CSR) ? 1'b1 : master_if.sresp_last;
    assign push_entry = {push_last, master_if.get_packed_response()};

    pzcorebus_response_fifo_ram #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_data  (push_entry),
        .i_pop   (pop),
        .o_data  (head_entry),
        .o_count (o_count)
    );

    assign o_empty   = (o_count == '0);
    assign o_full    = (o_count == COUNT_W'(DEPTH));
    assign head_last = head_entry[RESPONSE_W];

    // Accept is withheld whenever full, even if a pop frees a slot this cycle.
    assign master_if.mresp_accept = !o_full;
    assign slave_if.sresp_valid   = resp_valid;
    assign slave_if.sresp_last    = head_last;

    always_comb begin
        slave_if.put_packed_response(head_entry[RESPONSE_W-1:0]);
    end

    if (PACKET_MODE) begin : g_packet
        logic [COUNT_W-1:0]           packet_count;
        pzcorebus_response_fifo_state state;
        logic                         push_packet;
        logic                         pop_packet;

        assign push_packet = push && push_last;
        assign pop_packet  = pop && head_last;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                packet_count <= '0;
            end else if (push_packet && !pop_packet) begin
                packet_count <= packet_count + 1'b1;
            end else if (pop_packet && !push_packet) begin
                packet_count <= packet_count - 1'b1;
            end
        end

        // Once a non-last head is shown, the rest of its burst must follow
        // without valid dropping, even if the last beat is not stored yet.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                state <= GATE;
            end else begin
                case (state)
                    GATE:    if (resp_valid && !head_last) state <= RELEASE;
                    RELEASE: if (pop_packet)               state <= GATE;
                    default:                               state <= GATE;
                endcase
            end
        end

        always_comb begin
            if (state == RELEASE) begin
                resp_valid = !o_empty;
            end else begin
                resp_valid = !o_empty && ((packet_count != '0) || o_full);
            end
        end
    end else begin : g_stream
        assign resp_valid = !o_empty;
    end

endmodule

// File: tb/tb_pzcorebus_response_fifo.sv
// Randomized bench for the response FIFO: four configurations run in lockstep
// against a queue-based model of stored beats and burst release.
module tb_pzcorebus_response_fifo;
    import pzcorebus_pkg::*;

    localparam int N = 4;
    localparam pzcorebus_config MEM_CFG = '{profile: PZCOREBUS_MEMORY_H, data_width: 0, id_width: 0};
    localparam pzcorebus_config CSR_CFG = '{profile: PZCOREBUS_CSR, data_width: 0, id_width: 0};

    typedef logic [38:0] entry_t;

    // Instance 0: streaming D=4; 1: packet D=8; 2: packet D=4; 3: packet D=4 CSR.
    function automatic int depth_of(input int g);
        return (g == 1) ? 8 : 4;
    endfunction

    function automatic bit packet_of(input int g);
        return g != 0;
    endfunction

    function automatic bit csr_of(input int g);
        return g == 3;
    endfunction

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic        src_valid  [N];
    logic [1:0]  src_resp   [N];
    logic [3:0]  src_id     [N];
    logic [31:0] src_data   [N];
    logic        src_last   [N];
    logic        up_accept  [N];

    logic        dut_accept [N];
    logic        out_valid  [N];
    logic        out_last   [N];
    logic [1:0]  out_resp   [N];
    logic [3:0]  out_id     [N];
    logic [31:0] out_data   [N];
    logic        empty      [N];
    logic        full       [N];
    logic [3:0]  count      [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int              D   = depth_of(g);
        localparam pzcorebus_config CFG = csr_of(g) ? CSR_CFG : MEM_CFG;

        logic [$clog2(D+1)-1:0] dut_count;

        pzcorebus_if #(.BUS_CONFIG(CFG)) mif ();
        pzcorebus_if #(.BUS_CONFIG(CFG)) sif ();

        assign mif.sresp_valid  = src_valid[g];
        assign mif.sresp        = src_resp[g];
        assign mif.sid          = src_id[g];
        assign mif.sdata        = src_data[g];
        assign mif.sresp_last   = src_last[g];
        assign sif.mresp_accept = up_accept[g];

        assign dut_accept[g] = mif.mresp_accept;
        assign out_valid[g]  = sif.sresp_valid;
        assign out_last[g]   = sif.sresp_last;
        assign out_resp[g]   = sif.sresp;
        assign out_id[g]     = sif.sid;
        assign out_data[g]   = sif.sdata;
        assign count[g]      = 4'(dut_count);

        pzcorebus_response_fifo #(
            .BUS_CONFIG  (CFG),
            .DEPTH       (D),
            .PACKET_MODE (packet_of(g))
        ) u_dut (
            .i_clk     (clk),
            .i_rst     (rst),
            .slave_if  (sif),
            .master_if (mif),
            .o_empty   (empty[g]),
            .o_full    (full[g]),
            .o_count   (dut_count)
        );
    end

    int checks = 0;
    int errors = 0;

    entry_t model_q   [N][$];
    bit     committed [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Valid rule from the buffer's contract: anything stored in streaming mode;
    // in packet mode a complete burst, a full buffer, or a burst already begun.
    function automatic bit model_valid(input int i);
        bit has_last;
        has_last = 1'b0;
        if (model_q[i].size() == 0) return 1'b0;
        if (!packet_of(i)) return 1'b1;
        for (int k = 0; k < model_q[i].size(); k++) begin
            if (model_q[i][k][38]) has_last = 1'b1;
        end
        return committed[i] || has_last || (model_q[i].size() == depth_of(i));
    endfunction

    task automatic check_outputs();
        for (int i = 0; i < N; i++) begin
            int sz;
            bit ev;
            sz = model_q[i].size();
            ev = model_valid(i);
            check($sformatf("u%0d_count", i), 64'(count[i]), 64'(sz));
            check($sformatf("u%0d_empty", i), 64'(empty[i]), 64'(sz == 0));
            check($sformatf("u%0d_full", i), 64'(full[i]), 64'(sz == depth_of(i)));
            check($sformatf("u%0d_accept", i), 64'(dut_accept[i]), 64'(sz < depth_of(i)));
            check($sformatf("u%0d_valid", i), 64'(out_valid[i]), 64'(ev));
            if (ev) begin
                check($sformatf("u%0d_head", i),
                      64'({out_last[i], out_resp[i], out_id[i], out_data[i]}), 64'(model_q[i][0]));
            end
        end
    endtask

    // One cycle: check at the falling edge, drive new inputs, advance the model.
    task automatic step(input int pv, input int pa, input int pl);
        bit pushed [N];
        @(negedge clk);
        check_outputs();
        for (int i = 0; i < N; i++) begin
            bit ev;
            bit head_last;
            bit pop;
            bit push;
            ev = model_valid(i);
            head_last = ev ? model_q[i][0][38] : 1'b0;
            if (!src_valid[i] && ($urandom_range(99) < pv)) begin
                src_valid[i] = 1'b1;
                src_resp[i]  = 2'($urandom);
                src_id[i]    = 4'($urandom);
                src_data[i]  = $urandom;
                src_last[i]  = ($urandom_range(99) < pl);
            end
            up_accept[i] = ($urandom_range(99) < pa);
            pop  = ev && up_accept[i];
            push = src_valid[i] && (model_q[i].size() < depth_of(i));
            if (ev) begin
                if (pop && head_last) committed[i] = 1'b0;
                else if (!head_last)  committed[i] = 1'b1;
            end
            if (pop) void'(model_q[i].pop_front());
            if (push) begin
                model_q[i].push_back({(csr_of(i) ? 1'b1 : src_last[i]), src_resp[i], src_id[i], src_data[i]});
            end
            pushed[i] = push;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (pushed[i]) src_valid[i] = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_valid[i] = 1'b0;
            src_resp[i]  = '0;
            src_id[i]    = '0;
            src_data[i]  = '0;
            src_last[i]  = 1'b0;
            up_accept[i] = 1'b0;
            committed[i] = 1'b0;
        end
        @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // Streaming single beats with upstream always accepting.
        repeat (12) step(100, 100, 100);
        // Upstream stalled: fill to full, source holds the extra beat, then drain.
        repeat (10) step(100, 0, 100);
        repeat (14) step(0, 100, 100);
        // Bursts with idle gaps, then long bursts that overflow the small buffers.
        repeat (60) step(50, 100, 33);
        repeat (60) step(100, 100, 8);
        repeat (40) step(100, 70, 10);
        // Push and pop together at a steady occupancy.
        repeat (2) step(100, 0, 100);
        repeat (12) step(100, 100, 100);

        for (int b = 0; b < 16; b++) begin
            int pv;
            int pa;
            int pl;
            pv = $urandom_range(100, 20);
            pa = $urandom_range(100, 10);
            pl = $urandom_range(100, 5);
            repeat (50) step(pv, pa, pl);
        end

        // Asynchronous reset with beats stored, away from the clock edge.
        repeat (3) step(100, 0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("u%0d_rst_valid", i), 64'(out_valid[i]), 64'(0));
            check($sformatf("u%0d_rst_empty", i), 64'(empty[i]), 64'(1));
            check($sformatf("u%0d_rst_count", i), 64'(count[i]), 64'(0));
            check($sformatf("u%0d_rst_accept", i), 64'(dut_accept[i]), 64'(1));
            model_q[i].delete();
            committed[i] = 1'b0;
            src_valid[i] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;

        repeat (12) step(100, 100, 100);
        repeat (200) step(60, 60, 30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
